// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier: operating mode and control state.
package mult_pkg;

   typedef enum logic [1:0] {
      UNSIGNED = 2'b00,
      SIGNED   = 2'b01,
      UMAC     = 2'b10,
      SMAC     = 2'b11
   } func_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/addsub.sv
// W-bit adder/subtractor; subtraction is a + ~b + 1, so cout is not a borrow.
module addsub #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   logic [W-1:0] w_b;

   assign w_b           = b ^ {W{sub}};
   assign {cout, sum}   = {1'b0, a} + {1'b0, w_b} + {{W{1'b0}}, sub};
   assign ovf           = (a[W-1] == w_b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier (unsigned / radix-2 Booth) with optional accumulate,
// one step per clock; result and done appear N cycles after the accept edge.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clock,
   input  logic           n_reset,
   input  logic           start,
   input  logic [1:0]     func,
   input  logic [N-1:0]   m,
   input  logic [N-1:0]   q,
   input  logic           clear_acc,
   output logic           ready,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic           overflow
);

   localparam int CW = $clog2(N);

   state_t           r_state, w_state_nxt;
   func_t            r_func;
   logic [CW-1:0]    r_cnt;
   logic [N:0]       r_a;
   logic [N-1:0]     r_m, r_q;
   logic             r_qm1;
   logic [2*N-1:0]   r_acc, r_product;
   logic             r_overflow;

   logic             w_signed, w_mac, w_do_add, w_sub;
   logic [N:0]       w_b_ext, w_sum, w_new_a, w_sh_a;
   logic [N-1:0]     w_sh_q;
   logic [2*N-1:0]   w_result, w_acc_sum;
   logic             w_acc_cout, w_acc_ovf;
   logic             w_step_cout_unused, w_step_ovf_unused;

   assign w_signed = (r_func == SIGNED) || (r_func == SMAC);
   assign w_mac    = (r_func == UMAC)   || (r_func == SMAC);

   // A carries one guard bit so Booth is exact for M = -2^(N-1); in unsigned
   // mode that bit is the carry C and is always zero at the start of a step.
   assign w_b_ext  = w_signed ? {r_m[N-1], r_m} : {1'b0, r_m};
   assign w_do_add = w_signed ? (r_q[0] ^ r_qm1) : r_q[0];
   assign w_sub    = w_signed & r_q[0] & ~r_qm1;

   addsub #(.W(N+1)) u_step (
      .a    (r_a),
      .b    (w_b_ext),
      .sub  (w_sub),
      .sum  (w_sum),
      .cout (w_step_cout_unused),
      .ovf  (w_step_ovf_unused)
   );

   assign w_new_a  = w_do_add ? w_sum : r_a;
   assign w_sh_a   = {w_signed ? w_new_a[N] : 1'b0, w_new_a[N:1]};
   assign w_sh_q   = {w_new_a[0], r_q[N-1:1]};
   assign w_result = {w_sh_a[N-1:0], w_sh_q};

   addsub #(.W(2*N)) u_acc (
      .a    (r_acc),
      .b    (w_result),
      .sub  (1'b0),
      .sum  (w_acc_sum),
      .cout (w_acc_cout),
      .ovf  (w_acc_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (start) w_state_nxt = RUN;
         end
         RUN:  if (r_cnt == '0) w_state_nxt = DONE;
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!n_reset) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         r_func     <= UNSIGNED;
         r_cnt      <= '0;
         r_a        <= '0;
         r_m        <= '0;
         r_q        <= '0;
         r_qm1      <= 1'b0;
         r_acc      <= '0;
         r_product  <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (clear_acc) begin
                  r_acc      <= '0;
                  r_overflow <= 1'b0;
               end
               if (start) begin
                  r_func <= func_t'(func);
                  r_m    <= m;
                  r_q    <= q;
                  r_a    <= '0;
                  r_qm1  <= 1'b0;
                  r_cnt  <= CW'(N-1);
               end
            end
            RUN: begin
               r_a   <= w_sh_a;
               r_q   <= w_sh_q;
               r_qm1 <= r_q[0];
               r_cnt <= r_cnt - 1'b1;
               // Final step: publish the result so it is valid while DONE.
               if (r_cnt == '0) begin
                  if (w_mac) begin
                     r_acc     <= w_acc_sum;
                     r_product <= w_acc_sum;
                     if (w_signed ? w_acc_ovf : w_acc_cout) r_overflow <= 1'b1;
                  end else begin
                     r_product <= w_result;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign product  = r_product;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=4): directed cases plus random
// operations compared against an arithmetic model of product and accumulator.
module tb_seq_multiplier;

   localparam int N = 4;
   localparam int P = 2 * N;

   logic           clock = 1'b0;
   logic           n_reset;
   logic           start;
   logic [1:0]     func;
   logic [N-1:0]   m, q;
   logic           clear_acc;
   logic           ready, done;
   logic [P-1:0]   product;
   logic           overflow;

   int             vectors     = 0;
   int             miscompares = 0;

   logic [P-1:0]   m_acc, m_prod;
   logic           m_ovf;

   seq_multiplier #(.N(N)) dut (
      .clock     (clock),
      .n_reset   (n_reset),
      .start     (start),
      .func      (func),
      .m         (m),
      .q         (q),
      .clear_acc (clear_acc),
      .ready     (ready),
      .done      (done),
      .product   (product),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer multiply, then wrap/overflow by range checks.
   task automatic model(input logic [1:0] f, input logic [N-1:0] mm, input logic [N-1:0] qq,
                        input logic clr);
      longint a, b, s;
      logic [P-1:0] res;
      if (f[0]) begin
         a = longint'($signed(mm));
         b = longint'($signed(qq));
      end else begin
         a = longint'(mm);
         b = longint'(qq);
      end
      s   = a * b;
      res = s[P-1:0];
      if (clr) begin
         m_acc = '0;
         m_ovf = 1'b0;
      end
      if (f[1]) begin
         if (f[0]) begin
            s = longint'($signed(m_acc)) + longint'($signed(res));
            if (s > (longint'(1) <<< (P-1)) - 1 || s < -(longint'(1) <<< (P-1))) m_ovf = 1'b1;
         end else begin
            s = longint'(m_acc) + longint'(res);
            if (s >= (longint'(1) <<< P)) m_ovf = 1'b1;
         end
         m_acc  = s[P-1:0];
         m_prod = m_acc;
      end else begin
         m_prod = res;
      end
   endtask

   task automatic do_op(input logic [1:0] f, input logic [N-1:0] mm, input logic [N-1:0] qq,
                        input logic clr, input logic disturb);
      int cyc;
      model(f, mm, qq, clr);
      chk("ready_idle", ready, 1'b1);
      @(negedge clock);
      start = 1'b1; func = f; m = mm; q = qq; clear_acc = clr;
      @(posedge clock); #1;
      start = 1'b0; clear_acc = 1'b0;
      func = 2'($urandom); m = N'($urandom); q = N'($urandom);
      chk("ready_busy", ready, 1'b0);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
         if (disturb && cyc == 1) begin
            start = 1'b1; clear_acc = 1'b1;
         end else if (disturb && cyc == 2) begin
            start = 1'b0; clear_acc = 1'b0;
         end
      end
      chk("latency", cyc, N);
      chk("product", product, m_prod);
      chk("overflow", overflow, m_ovf);
      @(posedge clock); #1;
      chk("done_pulse", done, 1'b0);
      chk("ready_back", ready, 1'b1);
   endtask

   initial begin
      int seen;
      logic [1:0] rf;
      n_reset = 1'b0; start = 1'b0; func = '0; m = '0; q = '0; clear_acc = 1'b0;
      m_acc = '0; m_prod = '0; m_ovf = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_product", product, '0);
      chk("rst_overflow", overflow, 1'b0);
      @(negedge clock);
      n_reset = 1'b1;

      do_op(2'b00, 4'd6, 4'd14, 1'b0, 1'b0);
      chk("tp_unsigned", product, 8'h54);
      do_op(2'b01, 4'h8, 4'h8, 1'b0, 1'b0);
      chk("tp_booth_min", product, 8'h40);
      do_op(2'b01, 4'h3, 4'hB, 1'b0, 1'b0);
      chk("tp_booth_neg", product, 8'hF1);
      do_op(2'b01, 4'h7, 4'h0, 1'b0, 1'b0);
      chk("tp_booth_zero", product, 8'h00);

      do_op(2'b10, 4'd6, 4'd14, 1'b1, 1'b0);
      chk("tp_umac1", product, 8'h54);
      do_op(2'b10, 4'd6, 4'd14, 1'b0, 1'b0);
      chk("tp_umac2", product, 8'hA8);
      do_op(2'b10, 4'd6, 4'd14, 1'b0, 1'b0);
      chk("tp_umac3", product, 8'hFC);
      chk("tp_umac3_ovf", overflow, 1'b0);
      do_op(2'b10, 4'd6, 4'd14, 1'b0, 1'b0);
      chk("tp_umac4", product, 8'h50);
      chk("tp_umac4_ovf", overflow, 1'b1);

      // clear_acc alone in IDLE
      @(negedge clock);
      clear_acc = 1'b1;
      @(posedge clock); #1;
      clear_acc = 1'b0;
      m_acc = '0; m_ovf = 1'b0;
      chk("clr_ovf", overflow, 1'b0);
      chk("clr_product", product, 8'h50);
      chk("clr_no_done", done, 1'b0);

      do_op(2'b11, 4'h8, 4'h7, 1'b1, 1'b0);
      chk("tp_smac1", product, 8'hC8);
      do_op(2'b11, 4'h8, 4'h8, 1'b0, 1'b0);
      chk("tp_smac2", product, 8'h08);
      chk("tp_smac2_ovf", overflow, 1'b0);

      // start and clear_acc pulsed during RUN must be ignored
      do_op(2'b10, 4'd5, 4'd3, 1'b0, 1'b1);
      chk("busy_ignore", product, 8'h17);

      // reset during an unsigned run
      @(negedge clock);
      start = 1'b1; func = 2'b00; m = 4'd9; q = 4'd13;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      n_reset = 1'b0;
      @(posedge clock); #1;
      n_reset = 1'b1;
      m_acc = '0; m_ovf = 1'b0; m_prod = '0;
      chk("midrst_ready", ready, 1'b1);
      chk("midrst_product", product, '0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_ovf", overflow, 1'b0);
      seen = 0;
      repeat (N + 2) begin
         @(posedge clock); #1;
         if (done) seen++;
      end
      chk("midrst_no_done", seen, 0);
      do_op(2'b00, 4'd9, 4'd13, 1'b0, 1'b0);
      chk("midrst_fresh", product, 8'h75);

      // start held high: two results, one IDLE cycle between them
      @(negedge clock);
      start = 1'b1; func = 2'b00; m = 4'd2; q = 4'd3;
      seen = 0;
      repeat (2 * (N + 2)) begin
         @(posedge clock); #1;
         if (done) seen++;
      end
      start = 1'b0;
      chk("b2b_count", seen, 2);
      chk("b2b_product", product, 8'h06);
      m_prod = 8'h06;
      @(posedge clock); #1;

      repeat (40) begin
         rf = 2'($urandom);
         do_op(rf, N'($urandom), N'($urandom), ($urandom_range(0, 5) == 0), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
